core_arbiter: RTL
=================

CORE_ARBITER -- requirements
Module: core_arbiter

Interface
REQ-001 SHALL have parameter STALL_PAUSE, default 6, stall count driven to a paused or pausing core.
REQ-002 SHALL have parameter STALL_WRITE, default 6, stall count driven to the loser of a write conflict.
REQ-003 SHALL have parameter STALL_READ, default 3, stall count driven to the loser of a data-read conflict.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pr_1, pr_2  input  3 each  pause/resume command from core 1 / core 2: [2] valid, [1] 1=resume/0=pause, [0] target (0=core 1, 1=core 2).
REQ-007 wen_1, wen_2  input  1 each  core data-memory write request.
REQ-008 rd_1, rd_2  input  1 each  core data-memory read request (data-read address bit 16).
REQ-009 halt_1, halt_2  input  1 each  core halted indication.
REQ-010 stall_num_1, stall_num_2  output  3 each  stall count to core 1 / core 2; 0 = proceed.
REQ-011 run  output  2  registered run state: [0] core 1, [1] core 2; 1 = running.
REQ-012 prio  output  1  registered round-robin pointer: 0 = core 1 wins next conflict.
REQ-013 halt  output  1  registered, sticky system halt.
REQ-014 wconf_cnt, rconf_cnt  output  16 each  registered saturating write/read conflict counters.

Function
REQ-015 Command decode SHALL be: cmd_i valid when pr_i[2]==1; any non-0/1 bit (X/Z) SHALL be treated as invalid.
REQ-016 Pause-stall for core k SHALL assert when (run[k]==0 and no valid resume targeting k this cycle) or a valid pause targets k this cycle.
REQ-017 A pause-stalled core SHALL receive stall_num = STALL_PAUSE in the same cycle (combinational).
REQ-018 Write conflict SHALL be wen_1 & wen_2 with neither core pause-stalled.
REQ-019 Read conflict SHALL be rd_1 & rd_2 with neither core pause-stalled and no write conflict.
REQ-020 On a conflict, the core selected by prio SHALL receive 0 and the other SHALL receive STALL_WRITE (write) or STALL_READ (read) in the same cycle.
REQ-021 On the clock edge ending a conflict cycle, prio SHALL be set to the losing core.
REQ-022 prio SHALL be unchanged in cycles with no conflict.
REQ-023 Stall priority: pause-stall > write conflict > read conflict > 0.
REQ-024 run[t] SHALL update at the clock edge to pr_i[1] for a valid command with target t.
REQ-025 Two valid commands to the same target in one cycle: pr_1 SHALL win; commands to different targets SHALL both apply.
REQ-026 A core SHALL be allowed to pause or resume itself; a self-pause stalls it that same cycle.
REQ-027 wconf_cnt / rconf_cnt SHALL increment by 1 per conflict cycle and saturate at 16'hFFFF.
REQ-028 halt SHALL be set at the edge after a cycle with halt_1==1 and halt_2==1, and cleared only by reset.
REQ-029 Once halt==1, run, prio and both counters SHALL hold, and both stall_num outputs SHALL be 0.

Reset
REQ-030 At a clock edge with reset==1: run=2'b01, prio=0, halt=0, wconf_cnt=0, rconf_cnt=0.
REQ-031 While reset==1, stall_num_1 and stall_num_2 SHALL be 0 and all inputs SHALL be ignored.
REQ-032 Reset asserted mid-conflict or mid-command SHALL discard the pending update; no counter increment and no run change.

Verification
REQ-033 Reset, then idle -> run=01, stall_num_2=6 and stall_num_1=0 every cycle.
REQ-034 pr_1=3'b111 for one cycle -> stall_num_2=0 that cycle; run=11 after the edge; stall_num_2=0 afterwards.
REQ-035 run=11, wen_1=wen_2=1 for 3 consecutive cycles -> stall pairs (1,2) = (0,6), (6,0), (0,6); prio after each edge = 1, 0, 1; wconf_cnt=3.
REQ-036 run=11, rd_1=rd_2=1 and wen_1=wen_2=1 in the same cycle -> write rule applies (loser gets 6); rconf_cnt unchanged.
REQ-037 pr_1=3'b101 and pr_2=3'b111 in the same cycle -> pr_1 wins; run[1]=0 after the edge; stall_num_2=6 in that cycle.
REQ-038 halt_1=halt_2=1 for one cycle -> halt=1 after the edge and stays 1 with halts deasserted; wconf_cnt preset to FFFF stays FFFF on a further conflict.

Source files
------------

// File: rtl/core_arbiter.sv
// Dual-core arbiter: decodes pause/resume commands, resolves data-memory
// write/read conflicts round-robin, and latches a sticky system halt.
module core_arbiter #(
  parameter int unsigned STALL_PAUSE = 6,
  parameter int unsigned STALL_WRITE = 6,
  parameter int unsigned STALL_READ  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  pr_1,
  input  logic [2:0]  pr_2,
  input  logic        wen_1,
  input  logic        wen_2,
  input  logic        rd_1,
  input  logic        rd_2,
  input  logic        halt_1,
  input  logic        halt_2,
  output logic [2:0]  stall_num_1,
  output logic [2:0]  stall_num_2,
  output logic [1:0]  run,
  output logic        prio,
  output logic        halt,
  output logic [15:0] wconf_cnt,
  output logic [15:0] rconf_cnt
);

  localparam logic [2:0] StallPauseV = 3'(STALL_PAUSE);
  localparam logic [2:0] StallWriteV = 3'(STALL_WRITE);
  localparam logic [2:0] StallReadV  = 3'(STALL_READ);

  logic [1:0]  run_q, run_d;
  logic        prio_q, prio_d;
  logic        halt_q, halt_d;
  logic [15:0] wconfCnt_q, wconfCnt_d;
  logic [15:0] rconfCnt_q, rconfCnt_d;

  logic        cmdValid1, cmdValid2;
  logic [1:0]  hit1, hit2;
  logic [1:0]  pauseHit, resumeHit, pauseStall;
  logic        wConf, rConf, anyConf;

  // A command with any unknown bit is dropped; hitN is a one-hot target mask.
  always_comb begin
    cmdValid1 = pr_1[2] && !$isunknown(pr_1);
    cmdValid2 = pr_2[2] && !$isunknown(pr_2);
    hit1      = cmdValid1 ? (pr_1[0] ? 2'b10 : 2'b01) : 2'b00;
    hit2      = cmdValid2 ? (pr_2[0] ? 2'b10 : 2'b01) : 2'b00;
    pauseHit  = (hit1 & {2{~pr_1[1]}}) | (hit2 & {2{~pr_2[1]}});
    resumeHit = (hit1 & {2{pr_1[1]}})  | (hit2 & {2{pr_2[1]}});
    pauseStall = (~run_q & ~resumeHit) | pauseHit;
    wConf     = wen_1 && wen_2 && (pauseStall == 2'b00);
    rConf     = rd_1 && rd_2 && (pauseStall == 2'b00) && !wConf;
    anyConf   = wConf || rConf;
  end

  // prio_q == 0 means core 1 wins; the loser takes the write or read stall.
  always_comb begin
    stall_num_1 = 3'd0;
    stall_num_2 = 3'd0;
    if (!reset && !halt_q) begin
      if (pauseStall[0]) begin
        stall_num_1 = StallPauseV;
      end else if (wConf && prio_q) begin
        stall_num_1 = StallWriteV;
      end else if (rConf && prio_q) begin
        stall_num_1 = StallReadV;
      end
      if (pauseStall[1]) begin
        stall_num_2 = StallPauseV;
      end else if (wConf && !prio_q) begin
        stall_num_2 = StallWriteV;
      end else if (rConf && !prio_q) begin
        stall_num_2 = StallReadV;
      end
    end
  end

  // pr_1 takes precedence when both commands name the same target.
  always_comb begin
    run_d      = run_q;
    prio_d     = prio_q;
    halt_d     = halt_q | (halt_1 & halt_2);
    wconfCnt_d = wconfCnt_q;
    rconfCnt_d = rconfCnt_q;
    if (!halt_q) begin
      for (int t = 0; t < 2; t++) begin
        if (hit1[t]) begin
          run_d[t] = pr_1[1];
        end else if (hit2[t]) begin
          run_d[t] = pr_2[1];
        end
      end
      if (anyConf) begin
        prio_d = ~prio_q;
      end
      if (wConf && (wconfCnt_q != 16'hFFFF)) begin
        wconfCnt_d = wconfCnt_q + 16'd1;
      end
      if (rConf && (rconfCnt_q != 16'hFFFF)) begin
        rconfCnt_d = rconfCnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q      <= 2'b01;
      prio_q     <= 1'b0;
      halt_q     <= 1'b0;
      wconfCnt_q <= 16'd0;
      rconfCnt_q <= 16'd0;
    end else begin
      run_q      <= run_d;
      prio_q     <= prio_d;
      halt_q     <= halt_d;
      wconfCnt_q <= wconfCnt_d;
      rconfCnt_q <= rconfCnt_d;
    end
  end

  assign run       = run_q;
  assign prio      = prio_q;
  assign halt      = halt_q;
  assign wconf_cnt = wconfCnt_q;
  assign rconf_cnt = rconfCnt_q;

endmodule
